piano_play_ctrl: RTL

Synchronous playback controller and note-source arbiter for the FPGA piano. It generates the quarter-beat tick internally from the system clock and steps an external song ROM through its `STEP` index. It merges the ROM's note with live keyboard input into one registered note code for the tone generator and LED decoder. It replaces gating song progress on a beat edge with a single-clock, enable-based design.

---
 rtl/piano_play_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/piano_play_ctrl.sv
// piano_play_ctrl: song playback sequencer and note-source arbiter.
// A free-running quarter-beat counter (enabled only while playing) steps the
// external song ROM address; a registered arbiter chooses between the held
// manual key and the song note for the tone generator.
module piano_play_ctrl #(
  parameter int BEAT_DIV = 25_000_000,
  parameter int SONG_LEN = 110
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       STOP,
  input  logic       PAUSE,
  input  logic       LOOP,
  input  logic       KEY_VALID,
  input  logic [3:0] KEY_NOTE,
  input  logic [3:0] SONG_NOTE,
  output logic [6:0] STEP,
  output logic       BEAT,
  output logic [3:0] NOTE,
  output logic       BUSY
);

  localparam int CNT_W = $clog2(BEAT_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BEAT_DIV - 1);
  localparam logic [6:0]       STEP_LAST = 7'(SONG_LEN - 1);
  localparam logic [3:0]       NOTE_NONE = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       step_q, step_d;
  logic             beat_q, beat_d;
  logic [3:0]       note_q, note_d;

  // Codes above 8 carry no pitch; fold them onto "none".
  function automatic logic [3:0] sanitize(input logic [3:0] code);
    return (code > NOTE_NONE) ? NOTE_NONE : code;
  endfunction

  // Next-state logic: commands resolved STOP > START > PAUSE, beat counting in PLAY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    beat_d  = 1'b0;
    if (STOP) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      step_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            state_d = ST_PLAY;
            cnt_d   = '0;
            step_d  = '0;
          end
        end
        ST_PLAY: begin
          // The edge that samples PAUSE is still a playing cycle, so it counts;
          // this keeps each step at exactly BEAT_DIV cycles of PLAY.
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            beat_d = 1'b1;
            if (step_q != STEP_LAST) begin
              step_d = step_q + 7'd1;
            end else if (LOOP) begin
              step_d = '0;
            end else begin
              step_d  = '0;
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // START is ignored while playing and masks a coincident PAUSE.
          if (PAUSE && !START && (state_d == ST_PLAY)) begin
            state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          // Resume keeps the frozen counter value.
          if (START || PAUSE) begin
            state_d = ST_PLAY;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          step_d  = '0;
        end
      endcase
    end
  end

  // Note arbitration: held key wins, then the song while playing, else silence.
  always_comb begin
    note_d = NOTE_NONE;
    if (KEY_VALID) begin
      note_d = sanitize(KEY_NOTE);
    end else if (state_q == ST_PLAY) begin
      note_d = sanitize(SONG_NOTE);
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      beat_q  <= 1'b0;
      note_q  <= NOTE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      beat_q  <= beat_d;
      note_q  <= note_d;
    end
  end

  assign STEP = step_q;
  assign BEAT = beat_q;
  assign NOTE = note_q;
  assign BUSY = (state_q != ST_IDLE);

endmodule
